fifo_to_sram_burst: RTL and testbench

FIFO_TO_SRAM_BURST -- requirements
Module: fifo_to_sram_burst

---
 rtl/fifo_to_sram_burst.sv | 124 ++++++++++++
 tb/tb_fifo_to_sram_burst.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_sram_burst.sv
// Moves fixed-length bursts of words from a FIFO into an SRAM ring buffer (addr_base..addr_limit).
// Optional end-of-burst pulse output is enabled by defining FIFO_TO_SRAM_BURST_DONE_EN.
module fifo_to_sram_burst #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 5,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  input  logic                   enable,
  input  logic                   empty,
  input  logic [COUNT_WIDTH-1:0] fifo_number_samples,
  input  logic [COUNT_WIDTH-1:0] burst_len,
  input  logic [DATA_WIDTH-1:0]  fifo_data_in,
  input  logic                   data_done,
  input  logic [ADDR_WIDTH-1:0]  addr_base,
  input  logic [ADDR_WIDTH-1:0]  addr_limit,
  output logic                   pop,
  output logic [DATA_WIDTH-1:0]  sram_data_out,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic                   sram_start,
  output logic                   busy
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
  ,
  output logic                   burst_done
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = ADDR_WIDTH'(1);

  state_t                   state_r;
  logic [ADDR_WIDTH-1:0]    addr_r;
  logic [COUNT_WIDTH-1:0]   cnt_r;
  logic [COUNT_WIDTH-1:0]   len_r;
  logic                     start_ok_s;
  logic                     last_word_s;
  logic [ADDR_WIDTH-1:0]    addr_next_s;

  // A burst needs the whole burst already buffered so it never stalls on an empty FIFO.
  assign start_ok_s  = enable && !empty && (burst_len != '0) && (fifo_number_samples >= burst_len);
  assign last_word_s = (cnt_r == (len_r - CNT_ONE));
  assign addr_next_s = (addr_r == addr_limit) ? addr_base : (addr_r + ADDR_ONE);

  // Burst sequencer with registered strobes and SRAM write port.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_r       <= ST_IDLE;
      pop           <= 1'b0;
      sram_start    <= 1'b0;
      busy          <= 1'b0;
      sram_data_out <= '0;
      sram_addr     <= '0;
      addr_r        <= '0;
      cnt_r         <= '0;
      len_r         <= '0;
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
      burst_done    <= 1'b0;
`endif
    end else begin
      pop        <= 1'b0;
      sram_start <= 1'b0;
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
      burst_done <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          // Holding the address while enabled lets the next burst continue around the ring.
          if (!enable) begin
            addr_r <= addr_base;
          end
          if (start_ok_s) begin
            state_r <= ST_POP;
            pop     <= 1'b1;
            busy    <= 1'b1;
            cnt_r   <= '0;
            len_r   <= burst_len;
          end
        end
        ST_POP: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          sram_data_out <= fifo_data_in;
          sram_addr     <= addr_r;
          sram_start    <= 1'b1;
          state_r       <= ST_START;
        end
        ST_START: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (data_done) begin
            addr_r <= addr_next_s;
            if (last_word_s) begin
              state_r    <= ST_IDLE;
              busy       <= 1'b0;
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
              burst_done <= 1'b1;
`endif
            end else begin
              cnt_r   <= cnt_r + CNT_ONE;
              state_r <= ST_POP;
              pop     <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_to_sram_burst.sv
// Randomized self-checking bench for fifo_to_sram_burst with a FIFO model, an SRAM responder
// and a reference model of the expected write stream (data order + ring addresses).
module tb_fifo_to_sram_burst;

  localparam int DW = 32;
  localparam int CW = 5;
  localparam int AW = 10;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n;
  logic          enable;
  logic          empty;
  logic [CW-1:0] fifo_number_samples;
  logic [CW-1:0] burst_len;
  logic [DW-1:0] fifo_data_in = '0;
  logic          data_done;
  logic          auto_done = 1'b0;
  logic          stray_done;
  logic [AW-1:0] addr_base;
  logic [AW-1:0] addr_limit;
  logic          pop;
  logic [DW-1:0] sram_data_out;
  logic [AW-1:0] sram_addr;
  logic          sram_start;
  logic          busy;
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
  logic          burst_done;
`endif

  always #5 wb_clk = ~wb_clk;

  fifo_to_sram_burst #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .enable(enable), .empty(empty),
    .fifo_number_samples(fifo_number_samples), .burst_len(burst_len),
    .fifo_data_in(fifo_data_in), .data_done(data_done), .addr_base(addr_base),
    .addr_limit(addr_limit), .pop(pop), .sram_data_out(sram_data_out),
    .sram_addr(sram_addr), .sram_start(sram_start), .busy(busy)
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
    , .burst_done(burst_done)
`endif
  );

  // FIFO model: pushes come from the stimulus, read data appears the cycle after pop.
  logic [DW-1:0] mem [0:255];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr = 8'd0;
  logic [7:0]    fifo_cnt;
  assign fifo_cnt            = wr_ptr - rd_ptr;
  assign empty               = (fifo_cnt == 8'd0);
  assign fifo_number_samples = fifo_cnt[CW-1:0];
  assign data_done           = auto_done | stray_done;

  always @(posedge wb_clk) begin
    if (pop) begin
      fifo_data_in <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
    end
  end

  // SRAM responder and monitor: logs every write request and the values held at completion.
  int            done_delay = 2;
  int            pend = 0;
  int            wn = 0, dn = 0, pop_total = 0, pop_wide = 0, bd_total = 0;
  logic          pop_prev = 1'b0;
  logic [AW-1:0] st_addr [0:255];
  logic [DW-1:0] st_data [0:255];
  logic [AW-1:0] dn_addr [0:255];
  logic [DW-1:0] dn_data [0:255];

  always @(negedge wb_clk) begin
    auto_done <= 1'b0;
    if (pend > 0) begin
      if (pend == 1) begin
        auto_done           <= 1'b1;
        dn_addr[8'(dn)]     <= sram_addr;
        dn_data[8'(dn)]     <= sram_data_out;
        dn                  <= dn + 1;
      end
      pend <= pend - 1;
    end
    if (sram_start) begin
      pend            <= done_delay;
      st_addr[8'(wn)] <= sram_addr;
      st_data[8'(wn)] <= sram_data_out;
      wn              <= wn + 1;
    end
    if (pop) pop_total <= pop_total + 1;
    if (pop && pop_prev) pop_wide <= pop_wide + 1;
    pop_prev <= pop;
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
    if (burst_done) bd_total <= bd_total + 1;
`endif
  end

  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] model_addr;

  function automatic logic [AW-1:0] ring_next(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic [AW-1:0] l);
    return (a == l) ? b : AW'(a + 1);
  endfunction

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(d);
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge wb_clk);
      if (wn >= target && !busy && pend == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Park the block in IDLE with enable low so the address register reloads addr_base.
  task automatic setup_ring(input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(negedge wb_clk);
    enable     = 1'b0;
    addr_base  = b;
    addr_limit = l;
    repeat (2) @(negedge wb_clk);
    model_addr = b;
  endtask

  task automatic test_reset;
    wb_rst_n = 1'b0;
    repeat (8) @(negedge wb_clk);
    n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop got=%b exp=0", pop); end
    n_checks++; if (sram_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", sram_start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (sram_data_out !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", sram_data_out); end
    n_checks++; if (sram_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
    n_checks++; if (burst_done !== 1'b0) begin n_fail++; $display("FAIL reset_burst_done got=%b exp=0", burst_done); end
`endif
    wb_rst_n = 1'b1;
  endtask

  task automatic test_single_burst;
    int ws0, ds0, p0, w0, b0;
    bit ok;
    logic [DW-1:0] ed;
    burst_len  = 5'd4;
    done_delay = 2;
    setup_ring(10'h010, 10'h3FF);
    ws0 = wn; ds0 = dn; p0 = pop_total; w0 = pop_wide; b0 = bd_total;
    push_word(32'ha5b6c7d8); push_word(32'he9fa0123);
    push_word(32'h4567890a); push_word(32'h55555555);
    enable = 1'b1;
    wait_done(ws0 + 4, 200, ok);
    enable = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout writes=%0d exp=4", wn - ws0); end
    for (int i = 0; i < 4; i++) begin
      ed = exp_q.pop_front();
      n_checks++; if (st_data[8'(ws0+i)] !== ed) begin n_fail++; $display("FAIL single_data[%0d] got=%h exp=%h", i, st_data[8'(ws0+i)], ed); end
      n_checks++; if (st_addr[8'(ws0+i)] !== model_addr) begin n_fail++; $display("FAIL single_addr[%0d] got=%h exp=%h", i, st_addr[8'(ws0+i)], model_addr); end
      n_checks++; if (dn_data[8'(ds0+i)] !== ed || dn_addr[8'(ds0+i)] !== model_addr) begin n_fail++; $display("FAIL single_hold[%0d] got=%h@%h exp=%h@%h", i, dn_data[8'(ds0+i)], dn_addr[8'(ds0+i)], ed, model_addr); end
      model_addr = ring_next(model_addr, addr_base, addr_limit);
    end
    n_checks++; if (pop_total - p0 != 4) begin n_fail++; $display("FAIL single_pops got=%0d exp=4", pop_total - p0); end
    n_checks++; if (pop_wide != w0) begin n_fail++; $display("FAIL single_pop_width wide=%0d exp=0", pop_wide - w0); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got=%b exp=1", empty); end
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
    n_checks++; if (bd_total - b0 != 1) begin n_fail++; $display("FAIL single_burst_done got=%0d exp=1", bd_total - b0); end
`endif
  endtask

  task automatic test_threshold;
    int ws0, p0, pop_cyc, st_cyc;
    bit ok;
    logic [DW-1:0] ed;
    burst_len  = 5'd4;
    done_delay = $urandom_range(1, 4);
    setup_ring(10'h100, 10'h3FF);
    ws0 = wn; p0 = pop_total;
    for (int i = 0; i < 3; i++) push_word($urandom);
    enable = 1'b1;
    repeat (20) @(negedge wb_clk);
    n_checks++; if (pop_total != p0 || busy !== 1'b0) begin n_fail++; $display("FAIL thresh_no_pop pops=%0d busy=%b exp=0/0", pop_total - p0, busy); end
    push_word($urandom);
    pop_cyc = 0; st_cyc = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge wb_clk);
      if (pop && pop_cyc == 0) pop_cyc = k;
      if (sram_start && st_cyc == 0) st_cyc = k;
    end
    n_checks++; if (pop_cyc < 1 || pop_cyc > 2) begin n_fail++; $display("FAIL thresh_pop_latency got=%0d exp=1..2", pop_cyc); end
    n_checks++; if (st_cyc != 3) begin n_fail++; $display("FAIL thresh_start_latency got=%0d exp=3", st_cyc); end
    wait_done(ws0 + 4, 200, ok);
    enable = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL thresh_timeout writes=%0d exp=4", wn - ws0); end
    for (int i = 0; i < 4; i++) begin
      ed = exp_q.pop_front();
      n_checks++; if (st_data[8'(ws0+i)] !== ed || st_addr[8'(ws0+i)] !== model_addr) begin n_fail++; $display("FAIL thresh_write[%0d] got=%h@%h exp=%h@%h", i, st_data[8'(ws0+i)], st_addr[8'(ws0+i)], ed, model_addr); end
      model_addr = ring_next(model_addr, addr_base, addr_limit);
    end
  endtask

  task automatic test_wrap;
    int ws0;
    bit ok;
    logic [DW-1:0] ed;
    burst_len  = 5'd3;
    done_delay = $urandom_range(1, 4);
    setup_ring(10'h3FE, 10'h3FF);
    ws0 = wn;
    for (int i = 0; i < 3; i++) push_word($urandom);
    enable = 1'b1;
    wait_done(ws0 + 3, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout1 writes=%0d exp=3", wn - ws0); end
    for (int i = 0; i < 3; i++) push_word($urandom);
    wait_done(ws0 + 6, 200, ok);
    enable = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout2 writes=%0d exp=6", wn - ws0); end
    for (int i = 0; i < 6; i++) begin
      ed = exp_q.pop_front();
      n_checks++; if (st_data[8'(ws0+i)] !== ed || st_addr[8'(ws0+i)] !== model_addr) begin n_fail++; $display("FAIL wrap_write[%0d] got=%h@%h exp=%h@%h", i, st_data[8'(ws0+i)], st_addr[8'(ws0+i)], ed, model_addr); end
      model_addr = ring_next(model_addr, addr_base, addr_limit);
    end
  endtask

  task automatic test_reset_mid_burst;
    int ws0, p0;
    bit found, ok;
    logic [DW-1:0] ed;
    burst_len  = 5'd2;
    done_delay = 6;
    setup_ring(10'h020, 10'h3FF);
    ws0 = wn;
    push_word($urandom); push_word($urandom);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk);
      if (sram_start) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_no_start got=0 exp=1"); end
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    @(negedge wb_clk);
    n_checks++; if (busy !== 1'b0 || pop !== 1'b0 || sram_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl busy=%b pop=%b start=%b exp=000", busy, pop, sram_start); end
    n_checks++; if (sram_addr !== '0 || sram_data_out !== '0) begin n_fail++; $display("FAIL rstmid_outs addr=%h data=%h exp=0/0", sram_addr, sram_data_out); end
    wb_rst_n = 1'b1;
    enable   = 1'b0;
    p0 = pop_total;
    repeat (12) @(negedge wb_clk);
    n_checks++; if (busy !== 1'b0 || pop_total != p0 || wn != ws0 + 1) begin n_fail++; $display("FAIL rstmid_ignored busy=%b pops=%0d writes=%0d exp=0/0/1", busy, pop_total - p0, wn - ws0); end
    ed = exp_q.pop_front();
    n_checks++; if (st_data[8'(ws0)] !== ed) begin n_fail++; $display("FAIL rstmid_first got=%h exp=%h", st_data[8'(ws0)], ed); end
    burst_len  = 5'd1;
    done_delay = 2;
    model_addr = addr_base;
    enable     = 1'b1;
    wait_done(ws0 + 2, 100, ok);
    enable = 1'b0;
    ed = exp_q.pop_front();
    n_checks++; if (!ok || st_data[8'(ws0+1)] !== ed || st_addr[8'(ws0+1)] !== model_addr) begin n_fail++; $display("FAIL rstmid_drain ok=%b got=%h@%h exp=%h@%h", ok, st_data[8'(ws0+1)], st_addr[8'(ws0+1)], ed, model_addr); end
  endtask

  task automatic test_stray_done;
    int ws0, len;
    bit found, ok;
    logic [DW-1:0] ed;
    len        = $urandom_range(3, 6);
    burst_len  = CW'(len);
    done_delay = $urandom_range(1, 4);
    setup_ring(10'h040, 10'h04F);
    ws0 = wn;
    for (int i = 0; i < len; i++) push_word($urandom);
    stray_done = 1'b1;
    @(negedge wb_clk);
    stray_done = 1'b0;
    @(negedge wb_clk);
    n_checks++; if (busy !== 1'b0 || wn != ws0) begin n_fail++; $display("FAIL stray_idle busy=%b writes=%0d exp=0/0", busy, wn - ws0); end
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      if (pop) begin found = 1'b1; break; end
    end
    stray_done = 1'b1;
    @(negedge wb_clk);
    stray_done = 1'b0;
    @(negedge wb_clk);
    n_checks++; if (!found || sram_start !== 1'b1) begin n_fail++; $display("FAIL stray_pop found=%b start=%b exp=1/1", found, sram_start); end
    enable = 1'b0;
    wait_done(ws0 + len, 300, ok);
    repeat (5) @(negedge wb_clk);
    n_checks++; if (!ok || wn - ws0 != len || busy !== 1'b0) begin n_fail++; $display("FAIL stray_complete writes=%0d busy=%b exp=%0d/0", wn - ws0, busy, len); end
    for (int i = 0; i < len; i++) begin
      ed = exp_q.pop_front();
      n_checks++; if (st_data[8'(ws0+i)] !== ed || st_addr[8'(ws0+i)] !== model_addr) begin n_fail++; $display("FAIL stray_write[%0d] got=%h@%h exp=%h@%h", i, st_data[8'(ws0+i)], st_addr[8'(ws0+i)], ed, model_addr); end
      model_addr = ring_next(model_addr, addr_base, addr_limit);
    end
  endtask

  task automatic test_back_to_back;
    int ws0, p0, w0, b0, len, nw;
    bit ok;
    logic [DW-1:0] ed;
    logic [AW-1:0] b;
    for (int it = 0; it < 2; it++) begin
      len        = $urandom_range(2, 5);
      nw         = 3 * len;
      burst_len  = CW'(len);
      done_delay = $urandom_range(1, 4);
      b          = AW'($urandom_range(0, 512));
      setup_ring(b, AW'(b + AW'($urandom_range(2, 6))));
      ws0 = wn; p0 = pop_total; w0 = pop_wide; b0 = bd_total;
      for (int i = 0; i < nw; i++) push_word($urandom);
      enable = 1'b1;
      wait_done(ws0 + nw, 600, ok);
      enable = 1'b0;
      n_checks++; if (!ok || wn - ws0 != nw) begin n_fail++; $display("FAIL b2b_count writes=%0d exp=%0d", wn - ws0, nw); end
      for (int i = 0; i < nw; i++) begin
        ed = exp_q.pop_front();
        n_checks++; if (st_data[8'(ws0+i)] !== ed || st_addr[8'(ws0+i)] !== model_addr) begin n_fail++; $display("FAIL b2b_write[%0d] got=%h@%h exp=%h@%h", i, st_data[8'(ws0+i)], st_addr[8'(ws0+i)], ed, model_addr); end
        model_addr = ring_next(model_addr, addr_base, addr_limit);
      end
      n_checks++; if (pop_total - p0 != nw || pop_wide != w0) begin n_fail++; $display("FAIL b2b_pops got=%0d wide=%0d exp=%0d/0", pop_total - p0, pop_wide - w0, nw); end
`ifdef FIFO_TO_SRAM_BURST_DONE_EN
      n_checks++; if (bd_total - b0 != 3) begin n_fail++; $display("FAIL b2b_burst_done got=%0d exp=3", bd_total - b0); end
`endif
    end
  endtask

  initial begin
    wb_rst_n   = 1'b0;
    enable     = 1'b0;
    stray_done = 1'b0;
    burst_len  = 5'd0;
    addr_base  = 10'h000;
    addr_limit = 10'h3FF;
    test_reset;
    test_single_burst;
    test_threshold;
    test_wrap;
    test_reset_mid_burst;
    test_stray_done;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
